cfg0_tlp_engine: RTL and testbench
==================================

// Module: cfg0_tlp_engine
// PURPOSE
//  Converts cfg0w/cfg0r request handshakes (en/addr/data + op_start) into PCIe CfgWr0/CfgRd0 TLPs on the RC core AXI-S TX.
//  Matches returning Cpl/CplD on RX by tag, then reports data, status and op_over to the requester. Sits between the config-init sequencer and RC core.
// PARAMETERS
//  TGT_BUS      8'h01     target bus number (DW2[31:24])
//  TGT_DEV      5'h00     target device number
//  TGT_FUNC     3'h0      target function number
//  REQ_ID       16'h0000  requester ID (RC BDF) in DW1[31:16]
//  TAG_W        5         tag counter width, zero-extended to 8 bits
//  CPL_TIMEOUT  32'd50000 timeout in clk cycles (used only with CFG0_CPL_TIMEOUT_EN)
// PORTS
//  clk             in   1   RC core user clock
//  rst             in   1   synchronous, active-high reset
//  op_start        in   1   1-cycle request strobe
//  cfg0w_en        in   1   write request select, held until op_over seen
//  cfg0w_addr      in   32  write address; addr[11:2] = ext reg + reg number
//  cfg0w_data      in   32  write data DW
//  cfg0w_op_over   out  1   write done
//  cfg0r_en        in   1   read request select, held until op_over seen
//  cfg0r_addr      in   32  read address; addr[11:2] used
//  cfg0r_data      out  32  read data, held until next read completes
//  cfg0r_data_vld  out  1   1-cycle pulse, cfg0r_data valid
//  cfg0r_op_over   out  1   read done
//  cpl_status      out  3   last completion status (000 SC,001 UR,010 CRS,100 CA,111 timeout)
//  tx_tdata/tkeep  out  64/8  TLP to core; DW0 in [31:0], DW1 in [63:32]
//  tx_tvalid/tlast out  1/1 ; tx_tready in 1
//  rx_tdata        in   64  completion TLP from core, same lane order
//  rx_tvalid/tlast in   1/1 ; rx_tready out 1
// BEHAVIOUR
//  Reset: all outputs 0 (cpl_status 000, cfg0r_data 0), tag=0, FSM->IDLE; reset mid-op aborts at once, tx_tvalid drops.
//  rx_tready=1 in every state except reset: RX never back-pressured; non-matching/non-Cpl TLPs consumed and dropped.
//  FSM: IDLE -> TX_H0 -> TX_H1 -> WAIT_CPL -> CPL_D1 -> DONE -> IDLE.
//  IDLE: op_start & (cfg0w_en|cfg0r_en) latches addr/data/dir; both en high -> write wins. op_start in any other state ignored.
//  TX_H0: beat0 {DW1,DW0}, tkeep=FF. DW0: fmt/type 8'h44 wr / 8'h04 rd, TC/attr/TD/EP=0, length=1.
//         DW1: {REQ_ID, tag, lastBE 4'h0, firstBE 4'hF}. Advance on tvalid&tready.
//  TX_H1: beat1, tlast=1. DW2 {TGT_BUS,TGT_DEV,TGT_FUNC,4'h0,addr[11:8],addr[7:2],2'b00}.
//         DW3 = wr data with tkeep=FF; read sends tkeep=0F (DW3=0). tvalid held until tready; data stable.
//  WAIT_CPL: beat0 with DW0[31:24]=8'h0A (Cpl) or 8'h4A (CplD): capture status DW1[15:13] -> CPL_D1; otherwise drop TLP.
//  CPL_D1: beat1 DW2[15:8]==tag: read latches DW3 to cfg0r_data; -> DONE. Tag mismatch -> back to WAIT_CPL.
//  DONE: cpl_status updated; cfg0r_data_vld pulses 1 cycle (reads, any status; non-SC read data forced 32'hFFFFFFFF).
//        Matching op_over rises same cycle, held high while its en high; en low -> op_over 0 next cycle, ->IDLE, tag+=1 (wraps mod 2^TAG_W).
//  Latency: op_start to tx_tvalid = 1 cycle; RX last beat to op_over = 1 cycle.
//  CRS reported as status only, no automatic retry.
// CONFIGURATION
//  CFG0_CPL_TIMEOUT_EN defined: 32-bit counter cleared on WAIT_CPL entry; at CPL_TIMEOUT -> DONE with status 111, read data FFFFFFFF.
//    Late completion with the old tag is dropped (tag already advanced).
//  Not defined: no counter; WAIT_CPL waits indefinitely; status 111 never produced.
// STRUCTURE
//  cfg0_tlp_pkg: FMT_TYPE_CFGRD0/CFGWR0/CPL/CPLD constants, CPL_SC/UR/CRS/CA/TMO codes, state enum, DW field offsets.
//  Sub-module cfg0_cpl_parser: RX beat decode (type, status, tag match, data DW); FSM, TX builder, tag, timer in top.
// TESTING
//  1 Write addr 32'h0000_0004 data 32'h0011_0007, tready=1 -> beat0 DW0=4400_0001; beat1 DW2=0100_0004, DW3=0011_0007; Cpl SC -> op_over, status 000.
//  2 Read addr 32'h0 -> beat1 tkeep=0F; CplD SC data 32'hABCD_10EE -> cfg0r_data=ABCD10EE, vld 1 pulse, op_over held until en low.
//  3 tx_tready toggled 1/0 each cycle -> beats unchanged while stalled, exactly 2 beats, tlast on 2nd only.
//  4 Stray CplD with tag+1 before real Cpl -> dropped, real one completes; tag next request = old+1; 32 requests wrap tag to 0.
//  5 Read with UR Cpl -> status 001, cfg0r_data=FFFFFFFF; reset asserted in WAIT_CPL -> all outputs 0, next op runs clean.
//  6 CFG0_CPL_TIMEOUT_EN, CPL_TIMEOUT=100, no Cpl -> op_over at cycle 100 after WAIT_CPL entry, status 111.

Source files
------------

// File: rtl/cfg0_tlp_pkg.sv
// Shared definitions for the CfgRd0/CfgWr0 TLP engine: TLP fmt/type codes,
// completion status codes, FSM state encodings and header field offsets.
// No ports.
package cfg0_tlp_pkg;

    // fmt/type byte (DW0[31:24])
    localparam logic [7:0] FMT_TYPE_CFGRD0 = 8'h04;
    localparam logic [7:0] FMT_TYPE_CFGWR0 = 8'h44;
    localparam logic [7:0] FMT_TYPE_CPL    = 8'h0A;
    localparam logic [7:0] FMT_TYPE_CPLD   = 8'h4A;

    // Completion status as reported to the requester; TMO is local-only
    localparam logic [2:0] CPL_SC  = 3'b000;
    localparam logic [2:0] CPL_UR  = 3'b001;
    localparam logic [2:0] CPL_CRS = 3'b010;
    localparam logic [2:0] CPL_CA  = 3'b100;
    localparam logic [2:0] CPL_TMO = 3'b111;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_TX_H0    = 3'd1;
    localparam state_t ST_TX_H1    = 3'd2;
    localparam state_t ST_WAIT_CPL = 3'd3;
    localparam state_t ST_CPL_D1   = 3'd4;
    localparam state_t ST_DONE     = 3'd5;

    // Field offsets within a DW
    localparam int unsigned DW_FMT_TYPE_LSB = 24;  // DW0
    localparam int unsigned CPL_STATUS_LSB  = 13;  // completion DW1
    localparam int unsigned CPL_TAG_LSB     = 8;   // completion DW2

    // Config request DW2: target BDF plus DW-aligned register number
    function automatic logic [31:0] cfg_dw2(input logic [7:0] bus, input logic [4:0] dev,
                                            input logic [2:0] func, input logic [9:0] reg_dw);
        return {bus, dev, func, 4'h0, reg_dw, 2'b00};
    endfunction

endpackage

// File: rtl/cfg0_tlp_engine_if.sv
// 64-bit AXI-Stream link to/from the RC core.
// Signals: tdata[63:0] (DW0 in [31:0], DW1 in [63:32]), tkeep[7:0], tvalid, tlast, tready.
// Modports: master drives the stream, slave receives it.
interface cfg0_tlp_engine_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cfg0_cpl_parser.sv
// Combinational decode of one RX beat of a completion TLP.
// Ports:
//   rx_tdata  in  64  current RX beat
//   tag       in  8   tag of the outstanding request
//   is_cpl    out 1   beat0 view: fmt/type is Cpl or CplD
//   status    out 3   beat0 view: completion status DW1[15:13]
//   tag_match out 1   beat1 view: DW2[15:8] equals tag
//   data      out 32  beat1 view: DW3 payload
module cfg0_cpl_parser
    import cfg0_tlp_pkg::*;
(
    input  logic [63:0] rx_tdata,
    input  logic [7:0]  tag,
    output logic        is_cpl,
    output logic [2:0]  status,
    output logic        tag_match,
    output logic [31:0] data
);
    logic [31:0] dw_lo;  // DW0 on beat0, DW2 on beat1
    logic [31:0] dw_hi;  // DW1 on beat0, DW3 on beat1

    assign dw_lo = rx_tdata[31:0];
    assign dw_hi = rx_tdata[63:32];

    assign is_cpl    = (dw_lo[DW_FMT_TYPE_LSB +: 8] == FMT_TYPE_CPL) ||
                       (dw_lo[DW_FMT_TYPE_LSB +: 8] == FMT_TYPE_CPLD);
    assign status    = dw_hi[CPL_STATUS_LSB +: 3];
    assign tag_match = (dw_lo[CPL_TAG_LSB +: 8] == tag);
    assign data      = dw_hi;

    logic unused_dw_lo;
    assign unused_dw_lo = ^{dw_lo[23:16], dw_lo[7:0]};
endmodule

// File: rtl/cfg0_tlp_engine.sv
// Turns cfg0w/cfg0r request handshakes into CfgWr0/CfgRd0 TLPs on the RC core
// TX stream, matches the returning Cpl/CplD by tag on RX and reports data,
// status and op_over back to the requester.
// Ports:
//   clk, rst                     user clock, synchronous active-high reset
//   op_start                     1-cycle request strobe
//   cfg0w_en/addr/data/op_over   write request and done flag
//   cfg0r_en/addr/data/data_vld/op_over  read request, data and done flag
//   cpl_status                   last completion status (111 = timeout)
//   tx (master), rx (slave)      AXI-S to/from RC core
// Build option: CFG0_CPL_TIMEOUT_EN adds a completion timeout of CPL_TIMEOUT cycles.
module cfg0_tlp_engine
    import cfg0_tlp_pkg::*;
#(
    parameter logic [7:0]  TGT_BUS     = 8'h01,
    parameter logic [4:0]  TGT_DEV     = 5'h00,
    parameter logic [2:0]  TGT_FUNC    = 3'h0,
    parameter logic [15:0] REQ_ID      = 16'h0000,
    parameter int unsigned TAG_W       = 5,
    parameter logic [31:0] CPL_TIMEOUT = 32'd50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_start,
    input  logic               cfg0w_en,
    input  logic [31:0]        cfg0w_addr,
    input  logic [31:0]        cfg0w_data,
    output logic               cfg0w_op_over,
    input  logic               cfg0r_en,
    input  logic [31:0]        cfg0r_addr,
    output logic [31:0]        cfg0r_data,
    output logic               cfg0r_data_vld,
    output logic               cfg0r_op_over,
    output logic [2:0]         cpl_status,
    cfg0_tlp_engine_if.master  tx,
    cfg0_tlp_engine_if.slave   rx
);
    state_t           state_q, state_d;
    logic [TAG_W-1:0] tag_q;
    logic             is_wr_q;
    logic [9:0]       reg_q;
    logic [31:0]      wdata_q;
    logic [2:0]       pend_status_q;
    logic [2:0]       cpl_status_q;
    logic [31:0]      rdata_q;
    logic             vld_q;
    logic             rx_sof_q;  // next RX beat starts a TLP

    logic [7:0]  tag8;
    logic        rx_fire;
    logic        rx_is_cpl, rx_tag_match;
    logic [2:0]  rx_status;
    logic [31:0] rx_data;
    logic        timeout;
    logic        en_held;
    logic        done_entry;
    logic [2:0]  done_status;

    assign tag8    = 8'(tag_q);
    assign rx_fire = rx.tvalid & rx.tready;
    assign en_held = is_wr_q ? cfg0w_en : cfg0r_en;

    cfg0_cpl_parser u_cpl_parser (
        .rx_tdata  (rx.tdata),
        .tag       (tag8),
        .is_cpl    (rx_is_cpl),
        .status    (rx_status),
        .tag_match (rx_tag_match),
        .data      (rx_data)
    );

`ifdef CFG0_CPL_TIMEOUT_EN
    logic [31:0] timer_q;

    // Cleared while the header goes out so it starts at 0 on WAIT_CPL entry;
    // keeps running across tag-mismatch returns from CPL_D1.
    always_ff @(posedge clk) begin
        if (rst || state_q == ST_TX_H1) begin
            timer_q <= '0;
        end else if (state_q == ST_WAIT_CPL || state_q == ST_CPL_D1) begin
            timer_q <= timer_q + 32'd1;
        end
    end

    assign timeout = (state_q == ST_WAIT_CPL) && ((33'(timer_q) + 33'd1) >= 33'(CPL_TIMEOUT));
`else
    assign timeout = 1'b0;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^CPL_TIMEOUT;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (op_start && (cfg0w_en || cfg0r_en)) state_d = ST_TX_H0;
            ST_TX_H0:    if (tx.tready) state_d = ST_TX_H1;
            ST_TX_H1:    if (tx.tready) state_d = ST_WAIT_CPL;
            ST_WAIT_CPL: begin
                // Only a first beat that continues into a second can be our header
                if (rx_fire && rx_sof_q && rx_is_cpl && !rx.tlast) state_d = ST_CPL_D1;
                else if (timeout)                                   state_d = ST_DONE;
            end
            ST_CPL_D1:   if (rx_fire) state_d = rx_tag_match ? ST_DONE : ST_WAIT_CPL;
            ST_DONE:     if (!en_held) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    assign done_entry  = (state_d == ST_DONE) && (state_q != ST_DONE);
    assign done_status = timeout ? CPL_TMO : pend_status_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tag_q         <= '0;
            is_wr_q       <= 1'b0;
            reg_q         <= '0;
            wdata_q       <= '0;
            pend_status_q <= CPL_SC;
            cpl_status_q  <= CPL_SC;
            rdata_q       <= '0;
            vld_q         <= 1'b0;
            rx_sof_q      <= 1'b1;
        end else begin
            state_q <= state_d;
            vld_q   <= 1'b0;
            if (rx_fire) rx_sof_q <= rx.tlast;
            if (state_q == ST_IDLE && state_d == ST_TX_H0) begin
                is_wr_q <= cfg0w_en;  // write wins when both are selected
                reg_q   <= cfg0w_en ? cfg0w_addr[11:2] : cfg0r_addr[11:2];
                wdata_q <= cfg0w_data;
            end
            if (state_q == ST_WAIT_CPL && state_d == ST_CPL_D1) pend_status_q <= rx_status;
            if (done_entry) begin
                cpl_status_q <= done_status;
                if (!is_wr_q) begin
                    rdata_q <= (done_status == CPL_SC) ? rx_data : 32'hFFFF_FFFF;
                    vld_q   <= 1'b1;
                end
            end
            if (state_q == ST_DONE && state_d == ST_IDLE) tag_q <= tag_q + TAG_W'(1);
        end
    end

    // TX header beats
    logic [31:0] dw0, dw1, dw2, dw3;
    assign dw0 = {is_wr_q ? FMT_TYPE_CFGWR0 : FMT_TYPE_CFGRD0, 14'h0, 10'd1};
    assign dw1 = {REQ_ID, tag8, 4'h0, 4'hF};
    assign dw2 = cfg_dw2(TGT_BUS, TGT_DEV, TGT_FUNC, reg_q);
    assign dw3 = is_wr_q ? wdata_q : 32'h0;

    assign tx.tvalid = (state_q == ST_TX_H0) || (state_q == ST_TX_H1);
    assign tx.tlast  = (state_q == ST_TX_H1);
    assign tx.tdata  = (state_q == ST_TX_H0) ? {dw1, dw0} :
                       (state_q == ST_TX_H1) ? {dw3, dw2} : 64'h0;
    assign tx.tkeep  = (state_q == ST_TX_H0) ? 8'hFF :
                       (state_q == ST_TX_H1) ? (is_wr_q ? 8'hFF : 8'h0F) : 8'h00;

    assign rx.tready = !rst;

    assign cfg0w_op_over  = (state_q == ST_DONE) && is_wr_q;
    assign cfg0r_op_over  = (state_q == ST_DONE) && !is_wr_q;
    assign cfg0r_data     = rdata_q;
    assign cfg0r_data_vld = vld_q;
    assign cpl_status     = cpl_status_q;

    logic unused_in;
    assign unused_in = ^{cfg0w_addr[31:12], cfg0w_addr[1:0], cfg0r_addr[31:12], cfg0r_addr[1:0],
                         rx.tkeep};
endmodule

// File: tb/tb_cfg0_tlp_engine.sv
// Directed, table-driven bench for cfg0_tlp_engine with hand-written sequences
// for stalls, stray completions, reset mid-op, tag wrap and completion timeout.
module tb_cfg0_tlp_engine;
    localparam logic [7:0] FT_CPL  = 8'h0A;
    localparam logic [7:0] FT_CPLD = 8'h4A;
    localparam logic [7:0] FT_MWR  = 8'h40;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_start, cfg0w_en, cfg0r_en;
    logic [31:0] cfg0w_addr, cfg0w_data, cfg0r_addr;
    logic        cfg0w_op_over, cfg0r_op_over, cfg0r_data_vld;
    logic [31:0] cfg0r_data;
    logic [2:0]  cpl_status;

    cfg0_tlp_engine_if tx_if ();
    cfg0_tlp_engine_if rx_if ();

    cfg0_tlp_engine #(
        .TGT_BUS     (8'h01),
        .TGT_DEV     (5'h00),
        .TGT_FUNC    (3'h0),
        .REQ_ID      (16'h0000),
        .TAG_W       (5),
        .CPL_TIMEOUT (32'd100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .op_start       (op_start),
        .cfg0w_en       (cfg0w_en),
        .cfg0w_addr     (cfg0w_addr),
        .cfg0w_data     (cfg0w_data),
        .cfg0w_op_over  (cfg0w_op_over),
        .cfg0r_en       (cfg0r_en),
        .cfg0r_addr     (cfg0r_addr),
        .cfg0r_data     (cfg0r_data),
        .cfg0r_data_vld (cfg0r_data_vld),
        .cfg0r_op_over  (cfg0r_op_over),
        .cpl_status     (cpl_status),
        .tx             (tx_if),
        .rx             (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          failures = 0;
    logic [4:0]  tb_tag = 5'd0;
    logic [63:0] bt_data [2];
    logic [7:0]  bt_keep [2];
    logic        bt_last [2];
    int          bt_n;
    int          cyc_beat1;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] aw;
        logic [31:0] ar;
        logic [31:0] wd;
        logic [7:0]  ft;
        logic [2:0]  st;
        logic [31:0] cd;
        logic [31:0] e_dw0;
        logic [31:0] e_dw2;
        logic [31:0] e_dw3;
        logic [7:0]  e_keep1;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [7];
    vec_t v_stall, v_wr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic wr, input logic rd, input logic [31:0] aw,
                            input logic [31:0] ar, input logic [31:0] wd);
        @(negedge clk);
        cfg0w_en = wr; cfg0r_en = rd; cfg0w_addr = aw; cfg0r_addr = ar; cfg0w_data = wd;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
    endtask

    // Runs 12 cycles of TX; toggle=1 alternates tready starting stalled.
    task automatic collect(input bit toggle);
        logic [63:0] prev;
        bit          stalled;
        stalled = 0;
        prev    = '0;
        bt_n    = 0;
        chk("tx_latency", tx_if.tvalid, 1'b1);
        for (int c = 0; c < 12; c++) begin
            tx_if.tready = toggle ? (c % 2 == 1) : 1'b1;
            if (tx_if.tvalid) begin
                if (stalled) chk("stall_hold", tx_if.tdata, prev);
                if (tx_if.tready) begin
                    if (bt_n < 2) begin
                        bt_data[bt_n] = tx_if.tdata;
                        bt_keep[bt_n] = tx_if.tkeep;
                        bt_last[bt_n] = tx_if.tlast;
                    end
                    if (bt_n == 1) cyc_beat1 = cyc;
                    bt_n++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev    = tx_if.tdata;
                end
            end
            @(negedge clk);
        end
        tx_if.tready = 1'b1;
        chk("beat_count", bt_n, 2);
    endtask

    task automatic send_cpl(input logic [7:0] ft, input logic [2:0] st, input logic [7:0] tg,
                            input logic [31:0] d);
        rx_if.tvalid = 1'b1;
        rx_if.tlast  = 1'b0;
        rx_if.tdata  = {{16'h0100, st, 1'b0, 12'h004}, {ft, 14'h0, 10'd1}};
        @(negedge clk);
        rx_if.tlast  = 1'b1;
        rx_if.tdata  = {d, {16'h0000, tg, 8'h00}};
        @(negedge clk);
        rx_if.tvalid = 1'b0;
        rx_if.tlast  = 1'b0;
        rx_if.tdata  = '0;
    endtask

    task automatic check_beats(input vec_t v);
        chk("dw0", bt_data[0][31:0], v.e_dw0);
        chk("dw1", bt_data[0][63:32], {16'h0000, 3'b000, tb_tag, 8'h0F});
        chk("keep0", bt_keep[0], 8'hFF);
        chk("last0", bt_last[0], 1'b0);
        chk("dw2", bt_data[1][31:0], v.e_dw2);
        chk("dw3", bt_data[1][63:32], v.e_dw3);
        chk("keep1", bt_keep[1], v.e_keep1);
        chk("last1", bt_last[1], 1'b1);
    endtask

    task automatic release_op();
        cfg0w_en = 1'b0;
        cfg0r_en = 1'b0;
        @(negedge clk);
        chk("over_drop", {cfg0w_op_over, cfg0r_op_over}, 2'b00);
        tb_tag = tb_tag + 5'd1;
    endtask

    task automatic run_vec(input vec_t v, input bit toggle);
        start_op(v.wr, v.rd, v.aw, v.ar, v.wd);
        collect(toggle);
        check_beats(v);
        send_cpl(v.ft, v.st, {3'b000, tb_tag}, v.cd);
        chk("w_over", cfg0w_op_over, v.wr);
        chk("r_over", cfg0r_op_over, !v.wr);
        chk("vld", cfg0r_data_vld, !v.wr);
        chk("status", cpl_status, v.st);
        chk("rdata", cfg0r_data, v.e_rdata);
        @(negedge clk);
        chk("vld_pulse", cfg0r_data_vld, 1'b0);
        chk("over_held", cfg0w_op_over | cfg0r_op_over, 1'b1);
        release_op();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h4, 32'h0, 32'h0011_0007, FT_CPL, 3'b000, 32'h0,
                    32'h4400_0001, 32'h0100_0004, 32'h0011_0007, 8'hFF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h0, FT_CPLD, 3'b000, 32'hABCD_10EE,
                    32'h0400_0001, 32'h0100_0000, 32'h0, 8'h0F, 32'hABCD_10EE};
        vecs[2] = '{1'b0, 1'b1, 32'h0, 32'hFFC, 32'h0, FT_CPL, 3'b001, 32'h0,
                    32'h0400_0001, 32'h0100_0FFC, 32'h0, 8'h0F, 32'hFFFF_FFFF};
        vecs[3] = '{1'b1, 1'b0, 32'hA30, 32'h0, 32'hDEAD_BEEF, FT_CPL, 3'b100, 32'h0,
                    32'h4400_0001, 32'h0100_0A30, 32'hDEAD_BEEF, 8'hFF, 32'hFFFF_FFFF};
        vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h1234_5678, 32'h0, FT_CPL, 3'b010, 32'h0,
                    32'h0400_0001, 32'h0100_0678, 32'h0, 8'h0F, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 1'b1, 32'h10, 32'h20, 32'h5A5A_5A5A, FT_CPL, 3'b000, 32'h0,
                    32'h4400_0001, 32'h0100_0010, 32'h5A5A_5A5A, 8'hFF, 32'hFFFF_FFFF};
        vecs[6] = '{1'b0, 1'b1, 32'h0, 32'hF00, 32'h0, FT_CPLD, 3'b000, 32'h1234_5678,
                    32'h0400_0001, 32'h0100_0F00, 32'h0, 8'h0F, 32'h1234_5678};
        v_stall = '{1'b0, 1'b1, 32'h0, 32'h8, 32'h0, FT_CPLD, 3'b000, 32'h0F0F_1234,
                    32'h0400_0001, 32'h0100_0008, 32'h0, 8'h0F, 32'h0F0F_1234};
        v_wr    = '{1'b1, 1'b0, 32'h100, 32'h0, 32'hC0DE_0000, FT_CPL, 3'b000, 32'h0,
                    32'h4400_0001, 32'h0100_0100, 32'hC0DE_0000, 8'hFF, 32'h0};

        rst = 1'b1; op_start = 1'b0; cfg0w_en = 1'b0; cfg0r_en = 1'b0;
        cfg0w_addr = '0; cfg0w_data = '0; cfg0r_addr = '0;
        tx_if.tready = 1'b1;
        rx_if.tvalid = 1'b0; rx_if.tlast = 1'b0; rx_if.tdata = '0; rx_if.tkeep = 8'hFF;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tvalid", tx_if.tvalid, 1'b0);
        chk("rst_rx_tready", rx_if.tready, 1'b0);
        chk("rst_outs", {cfg0w_op_over, cfg0r_op_over, cfg0r_data_vld, cpl_status, cfg0r_data},
            38'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rx_tready", rx_if.tready, 1'b1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

        // Back-pressured TX
        run_vec(v_stall, 1'b1);

        // Stray completions ahead of the real one
        start_op(1'b0, 1'b1, 32'h0, 32'h40, 32'h0);
        collect(1'b0);
        send_cpl(FT_CPLD, 3'b000, {3'b000, tb_tag + 5'd1}, 32'hBAD0_BAD0);
        chk("stray_over", cfg0r_op_over, 1'b0);
        send_cpl(FT_MWR, 3'b000, {3'b000, tb_tag}, 32'hBAD1_BAD1);
        chk("nocpl_over", cfg0r_op_over, 1'b0);
        send_cpl(FT_CPLD, 3'b000, {3'b000, tb_tag}, 32'h600D_600D);
        chk("real_over", cfg0r_op_over, 1'b1);
        chk("real_rdata", cfg0r_data, 32'h600D_600D);
        release_op();

        // UR read, then reset while waiting for a completion
        run_vec(vecs[2], 1'b0);
        start_op(1'b0, 1'b1, 32'h0, 32'h44, 32'h0);
        collect(1'b0);
        rst = 1'b1;
        cfg0r_en = 1'b0;
        @(negedge clk);
        chk("mid_rst_tvalid", tx_if.tvalid, 1'b0);
        chk("mid_rst_outs", {cfg0w_op_over, cfg0r_op_over, cfg0r_data_vld, cpl_status,
                             cfg0r_data}, 38'h0);
        @(negedge clk);
        rst = 1'b0;
        tb_tag = 5'd0;
        @(negedge clk);

        // 32 requests bring the tag back to 0
        for (int i = 0; i < 32; i++) run_vec(v_wr, 1'b0);
        run_vec(v_wr, 1'b0);
        chk("tag_wrap", bt_data[0][47:40], 8'h00);

`ifdef CFG0_CPL_TIMEOUT_EN
        begin
            int         seen;
            logic [7:0] old_tag;
            seen = -1;
            old_tag = {3'b000, tb_tag};
            start_op(1'b0, 1'b1, 32'h0, 32'h8, 32'h0);
            collect(1'b0);
            for (int i = 0; i < 300; i++) begin
                if (cfg0r_op_over) begin
                    seen = cyc;
                    break;
                end
                @(negedge clk);
            end
            chk("tmo_cycles", 64'(seen - cyc_beat1 - 1), 64'd100);
            chk("tmo_status", cpl_status, 3'b111);
            chk("tmo_rdata", cfg0r_data, 32'hFFFF_FFFF);
            chk("tmo_vld", cfg0r_data_vld, 1'b1);
            release_op();
            send_cpl(FT_CPLD, 3'b000, old_tag, 32'h1234_0000);
            chk("late_over", cfg0r_op_over, 1'b0);
            chk("late_vld", cfg0r_data_vld, 1'b0);
        end
`else
        start_op(1'b0, 1'b1, 32'h0, 32'h8, 32'h0);
        collect(1'b0);
        repeat (150) @(negedge clk);
        chk("no_tmo_over", cfg0r_op_over, 1'b0);
        chk("no_tmo_status", cpl_status, 3'b000);
        send_cpl(FT_CPLD, 3'b000, {3'b000, tb_tag}, 32'h0BAD_CAFE);
        chk("slow_over", cfg0r_op_over, 1'b1);
        chk("slow_rdata", cfg0r_data, 32'h0BAD_CAFE);
        release_op();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
